// File: rtl/noc_pkg.sv
// Shared types and default sizes for the BiNoC router channel allocator.
package noc_pkg;

    localparam int DEFAULT_NUM_IN = 5;   // requesters (input-port RC units)
    localparam int DEFAULT_NUM_CH = 10;  // 5 directions x 2 bidirectional channels

    typedef logic [$clog2(DEFAULT_NUM_CH)-1:0] ch_idx_t;
    typedef logic [$clog2(DEFAULT_NUM_IN)-1:0] in_idx_t;
    typedef logic [DEFAULT_NUM_CH-1:0]         ch_vec_t;

    // Per-requester allocation state.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin picker: first set request at or after ptr, wrapping.
module rr_arb #(
    parameter  int N  = 5,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          found
);

    logic [PW:0] idx;

    // Walk the requests from ptr upward with wrap-around; first hit wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW + 1)'(k);
            if (idx >= (PW + 1)'(N)) idx = idx - (PW + 1)'(N);
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_allocator.sv
// Output-channel allocator: grants each requesting RC one free output channel,
// round-robin per channel, held until the packet tail is released.
module channel_allocator
    import noc_pkg::*;
#(
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int NUM_CH = DEFAULT_NUM_CH
) (
    input  logic                     clk,
    input  logic                     rst,          // asynchronous, active-low
    input  logic [NUM_IN-1:0]        req_vld,
    input  logic [NUM_IN*NUM_CH-1:0] channel_req,  // requester i at [i*NUM_CH +: NUM_CH]
    input  logic [NUM_IN-1:0]        pkt_release,  // tail of requester i left this cycle
    input  logic [NUM_CH-1:0]        ch_avail,
    output logic [NUM_IN-1:0]        gnt,
    output logic [NUM_IN*NUM_CH-1:0] gntOutCntr,   // one-hot held channel per requester
    output logic [NUM_CH-1:0]        ch_busy
);

    localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    alloc_state_e              state      [NUM_IN];
    alloc_state_e              state_next [NUM_IN];
    logic [PW-1:0]             rr_ptr      [NUM_CH];
    logic [PW-1:0]             rr_ptr_next [NUM_CH];
    logic [NUM_IN*NUM_CH-1:0]  row_q, row_next, alloc;
    logic [NUM_CH-1:0]         busy_q, busy_next, ch_found;
    logic [NUM_IN-1:0]         eligible;

    // A requester competes only while idle, requesting, and not releasing.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = (state[i] == IDLE) && req_vld[i] && !pkt_release[i];
        end
    end

    // One arbiter per channel, ascending; lower channels' winners are masked out above.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NUM_IN-1:0] taken_in, taken_out, cand, pick;
        logic              found;
        logic              chan_free;

        if (c == 0) begin : g_first
            assign taken_in = '0;
        end else begin : g_rest
            assign taken_in = g_ch[c-1].taken_out;
        end

        for (genvar i = 0; i < NUM_IN; i++) begin : g_req
            assign cand[i]             = eligible[i] & channel_req[i*NUM_CH + c] & ~taken_in[i];
            assign alloc[i*NUM_CH + c] = pick[i];
        end

        // A held channel is busy, so one being released this cycle is never free either.
        assign chan_free = ~busy_q[c] & ch_avail[c];

        rr_arb #(.N(NUM_IN)) u_arb (
            .ptr   (rr_ptr[c]),
            .req   (cand & {NUM_IN{chan_free}}),
            .gnt   (pick),
            .found (found)
        );

        assign taken_out   = taken_in | pick;
        assign ch_found[c] = found;
    end

    // Next-state: FSM transitions, held-channel rows, busy map and pointer advance.
    always_comb begin
        busy_next = busy_q;
        row_next  = row_q;
        for (int i = 0; i < NUM_IN; i++) begin
            state_next[i] = state[i];
            if (state[i] == IDLE) begin
                if (|alloc[i*NUM_CH +: NUM_CH]) begin
                    state_next[i]                = HOLD;
                    row_next[i*NUM_CH +: NUM_CH] = alloc[i*NUM_CH +: NUM_CH];
                end
            end else if (pkt_release[i]) begin
                state_next[i]                = IDLE;
                busy_next                    = busy_next & ~row_q[i*NUM_CH +: NUM_CH];
                row_next[i*NUM_CH +: NUM_CH] = '0;
            end
        end
        busy_next = busy_next | ch_found;

        for (int c = 0; c < NUM_CH; c++) begin
            rr_ptr_next[c] = rr_ptr[c];
            for (int i = 0; i < NUM_IN; i++) begin
                if (alloc[i*NUM_CH + c]) begin
                    rr_ptr_next[c] = (i == NUM_IN - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    // State, pointer and output registers; reset clears every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_IN; i++) state[i] <= IDLE;
            for (int c = 0; c < NUM_CH; c++) rr_ptr[c] <= '0;
            row_q  <= '0;
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < NUM_IN; i++) state[i] <= state_next[i];
            for (int c = 0; c < NUM_CH; c++) rr_ptr[c] <= rr_ptr_next[c];
            row_q  <= row_next;
            busy_q <= busy_next;
        end
    end

    // Registered outputs only.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) gnt[i] = (state[i] == HOLD);
        gntOutCntr = row_q;
        ch_busy    = busy_q;
    end

endmodule

// File: tb/tb_channel_allocator.sv
// Directed self-checking bench for channel_allocator.
module tb_channel_allocator;
    import noc_pkg::*;

    localparam int NI = DEFAULT_NUM_IN;
    localparam int NC = DEFAULT_NUM_CH;

    logic               clk = 1'b0;
    logic               rst;
    logic [NI-1:0]      req_vld;
    logic [NI*NC-1:0]   channel_req;
    logic [NI-1:0]      pkt_release;
    logic [NC-1:0]      ch_avail;
    logic [NI-1:0]      gnt;
    logic [NI*NC-1:0]   gntOutCntr;
    logic [NC-1:0]      ch_busy;

    logic [NC-1:0]      creq [NI];

    int n_vec = 0;
    int n_err = 0;

    channel_allocator #(.NUM_IN(NI), .NUM_CH(NC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .channel_req (channel_req),
        .pkt_release (pkt_release),
        .ch_avail    (ch_avail),
        .gnt         (gnt),
        .gntOutCntr  (gntOutCntr),
        .ch_busy     (ch_busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NI; i++) channel_req[i*NC +: NC] = creq[i];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NC-1:0] row(input int i);
        return gntOutCntr[i*NC +: NC];
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_vld     = '0;
        pkt_release = '0;
        ch_avail    = '1;
        for (int i = 0; i < NI; i++) creq[i] = '0;
    endtask

    // Short asynchronous reset pulse between edges.
    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        #1;
        check("reset gnt", 64'(gnt), 64'h0);
        check("reset gntOutCntr", 64'(gntOutCntr), 64'h0);
        check("reset ch_busy", 64'(ch_busy), 64'h0);
        step();
        step();
        rst = 1'b1;

        // Single grant: lowest acceptable channel.
        req_vld[0] = 1'b1;
        creq[0]    = 10'h003;
        step();
        check("single gnt", 64'(gnt), 64'h01);
        check("single row0", 64'(row(0)), 64'h001);
        check("single busy", 64'(ch_busy), 64'h001);
        creq[0] = 10'h002;
        step();
        check("hold ignores req row0", 64'(row(0)), 64'h001);
        req_vld[0]     = 1'b0;
        pkt_release[0] = 1'b1;
        step();
        check("single release gnt", 64'(gnt), 64'h00);
        check("single release busy", 64'(ch_busy), 64'h000);
        pkt_release[0] = 1'b0;
        step();
        check("idle release ignored", 64'(gnt), 64'h00);

        // Round-robin on channel 0 between requesters 0 and 1.
        pulse_reset();
        clear_inputs();
        creq[0] = 10'h001;
        creq[1] = 10'h001;
        req_vld = 5'b00011;
        step();
        check("rr first gnt", 64'(gnt), 64'h01);
        pkt_release[0] = 1'b1;
        step();
        check("rr release gnt", 64'(gnt), 64'h00);
        check("rr release busy", 64'(ch_busy), 64'h000);
        pkt_release[0] = 1'b0;
        step();
        check("rr second gnt", 64'(gnt), 64'h02);
        check("rr second row1", 64'(row(1)), 64'h001);
        pkt_release[1] = 1'b1;
        step();
        check("rr release1 gnt", 64'(gnt), 64'h00);
        pkt_release[1] = 1'b0;
        step();
        check("rr third gnt", 64'(gnt), 64'h01);
        req_vld        = '0;
        pkt_release[0] = 1'b1;
        step();

        // Greedy split: three requesters over channels 0 and 1.
        pulse_reset();
        clear_inputs();
        for (int i = 0; i < 3; i++) creq[i] = 10'h003;
        req_vld = 5'b00111;
        step();
        check("split gnt", 64'(gnt), 64'h03);
        check("split row0", 64'(row(0)), 64'h001);
        check("split row1", 64'(row(1)), 64'h002);
        check("split row2", 64'(row(2)), 64'h000);
        check("split busy", 64'(ch_busy), 64'h003);
        req_vld[0]     = 1'b0;
        pkt_release[0] = 1'b1;
        step();
        check("split release gnt", 64'(gnt), 64'h02);
        check("split release busy", 64'(ch_busy), 64'h002);
        pkt_release[0] = 1'b0;
        step();
        check("split late gnt", 64'(gnt), 64'h06);
        check("split late row2", 64'(row(2)), 64'h001);
        check("split late busy", 64'(ch_busy), 64'h003);
        req_vld     = '0;
        pkt_release = 5'b00110;
        step();
        check("split all released", 64'(ch_busy), 64'h000);
        clear_inputs();

        // Availability gating and loss of availability while held.
        ch_avail   = 10'h3FE;
        creq[3]    = 10'h001;
        req_vld[3] = 1'b1;
        step();
        check("avail blocked gnt", 64'(gnt), 64'h00);
        ch_avail = 10'h3FF;
        step();
        check("avail grant gnt", 64'(gnt), 64'h08);
        check("avail grant row3", 64'(row(3)), 64'h001);
        ch_avail = 10'h3FE;
        step();
        check("avail drop gnt", 64'(gnt), 64'h08);
        check("avail drop busy", 64'(ch_busy), 64'h001);
        req_vld        = '0;
        pkt_release[3] = 1'b1;
        step();
        check("avail release gnt", 64'(gnt), 64'h00);
        clear_inputs();

        // Empty candidate vector: no grant.
        req_vld[2] = 1'b1;
        step();
        check("empty req gnt", 64'(gnt), 64'h00);
        req_vld[2] = 1'b0;

        // Simultaneous release and request.
        creq[0]    = 10'h004;
        req_vld[0] = 1'b1;
        step();
        check("simul grant row0", 64'(row(0)), 64'h004);
        pkt_release[0] = 1'b1;
        step();
        check("simul release gnt", 64'(gnt), 64'h00);
        pkt_release[0] = 1'b0;
        step();
        check("simul regrant gnt", 64'(gnt), 64'h01);
        check("simul regrant row0", 64'(row(0)), 64'h004);
        creq[0] = 10'h010;
        step();
        check("simul hold row0", 64'(row(0)), 64'h004);
        req_vld        = '0;
        pkt_release[0] = 1'b1;
        step();
        clear_inputs();

        // Reset mid-operation with five grants held.
        creq[0] = 10'h004;
        creq[1] = 10'h010;
        creq[2] = 10'h040;
        creq[3] = 10'h001;
        creq[4] = 10'h100;
        req_vld = 5'b11111;
        step();
        check("five gnt", 64'(gnt), 64'h1F);
        check("five busy", 64'(ch_busy), 64'h155);
        req_vld = '0;
        step();
        #3;
        rst = 1'b0;
        #1;
        check("async reset gnt", 64'(gnt), 64'h00);
        check("async reset gntOutCntr", 64'(gntOutCntr), 64'h0);
        check("async reset busy", 64'(ch_busy), 64'h000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        creq[3] = 10'h001;
        creq[4] = 10'h001;
        req_vld = 5'b11000;
        step();
        check("post reset ptr0 gnt", 64'(gnt), 64'h08);
        check("post reset row3", 64'(row(3)), 64'h001);
        req_vld[3]     = 1'b0;
        pkt_release[3] = 1'b1;
        step();
        check("post reset release", 64'(gnt), 64'h00);
        pkt_release[3] = 1'b0;
        step();
        check("post reset gnt4", 64'(gnt), 64'h10);
        check("post reset row4", 64'(row(4)), 64'h001);
        check("post reset busy", 64'(ch_busy), 64'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
